// File: rtl/freq_counter_bcd_if.sv
// Bus bundle for freq_counter_bcd: the measured input plus the BCD result and
// the multiplexed 7-segment drive.
interface freq_counter_bcd_if;
  logic        sig_in;
  logic [15:0] freq_bcd;
  logic        ovf;
  logic        valid;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;

  modport master (output sig_in, input freq_bcd, ovf, valid, an_n, seg_n);
  modport slave  (input sig_in, output freq_bcd, ovf, valid, an_n, seg_n);
endinterface

// File: rtl/freq_counter_bcd.sv
// Counts rising edges of sig_in over a fixed gate window, latches the 4-digit
// BCD result (saturating at 9999) and scans it onto a common-anode display.
module freq_counter_bcd #(
  parameter int GATE_CYCLES = 50000000,
  parameter int SCAN_CYCLES = 50000
) (
  input  logic               clki,
  input  logic               rst,
  freq_counter_bcd_if.slave  bus
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

  logic          sync1, sync2, prev;
  logic          edge_det;
  logic [GW-1:0] gate_cnt;
  logic          gate_end;
  logic [15:0]   acc, acc_next;
  logic          acc_ovf, ovf_next;
  logic [15:0]   freq_q;
  logic          ovf_q;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    nibble;
  logic [6:0]    seg;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clki) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= bus.sig_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edge_det = sync2 & ~prev;
  assign gate_end = (gate_cnt == GATE_LAST);

  always_ff @(posedge clki) begin
    if (rst || gate_end) gate_cnt <= '0;
    else                 gate_cnt <= gate_cnt + 1'b1;
  end

  // A further edge at 9999 holds the count and only raises the sticky overflow.
  always_comb begin
    acc_next = acc;
    ovf_next = acc_ovf;
    if (edge_det) begin
      if (acc == 16'h9999) ovf_next = 1'b1;
      else                 acc_next = bcd_inc(acc);
    end
  end

  // The gate-end edge goes into the published result, then the window restarts empty.
  always_ff @(posedge clki) begin
    if (rst) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
      freq_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (gate_end) begin
      freq_q  <= acc_next;
      ovf_q   <= ovf_next;
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else begin
      acc     <= acc_next;
      acc_ovf <= ovf_next;
    end
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
    end
  end

  // Overflow forces every digit to 9 rather than using a separate indicator.
  always_comb begin
    nibble = 4'd0;
    seg    = 7'b1111111;
    case (digit_idx)
      2'd0: nibble = freq_q[3:0];
      2'd1: nibble = freq_q[7:4];
      2'd2: nibble = freq_q[11:8];
      2'd3: nibble = freq_q[15:12];
      default: nibble = 4'd0;
    endcase
    if (ovf_q) nibble = 4'd9;
    case (nibble)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

  assign bus.freq_bcd = freq_q;
  assign bus.ovf      = ovf_q;
  assign bus.valid    = gate_end & ~rst;
  assign bus.an_n     = ~(4'b0001 << digit_idx);
  assign bus.seg_n    = seg;

endmodule

// File: tb/tb_freq_counter_bcd.sv
// Directed bench for freq_counter_bcd: a short-gate instance walks a table of
// per-window edge counts and reset cases while a long-gate instance saturates.
module tb_freq_counter_bcd;

  typedef struct {
    int          rises;
    logic [15:0] exp_freq;
    logic        exp_ovf;
  } vec_t;

  logic clk;
  logic rst, rst2;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  vec_t vecs[7];

  freq_counter_bcd_if bus();
  freq_counter_bcd_if bus2();

  freq_counter_bcd #(.GATE_CYCLES(100), .SCAN_CYCLES(4)) dut (
    .clki(clk), .rst(rst), .bus(bus)
  );

  freq_counter_bcd #(.GATE_CYCLES(40000), .SCAN_CYCLES(4)) dut_big (
    .clki(clk), .rst(rst2), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] f, input logic o, input int idx);
    logic [3:0] d;
    d = o ? 4'd9 : f[idx*4 +: 4];
    return seg_of(d);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got %h, want %h", name, $time, actual, expected);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    check_output("rst_freq", bus.freq_bcd, 32'h0);
    check_output("rst_ovf", bus.ovf, 32'h0);
    check_output("rst_valid", bus.valid, 32'h0);
    check_output("rst_an", bus.an_n, 32'hE);
    check_output("rst_seg", bus.seg_n, 32'h40);
    rst = 1'b0;
    cyc = 0;
  endtask

  // Rises at window cycles 4i+1 (falls at 4i+3) land as synchronized edges at
  // cycles 4i+3, so 25 rises put the last edge exactly on the gate-end cycle.
  task automatic apply_stimulus(input int rises, input logic [15:0] held_f,
                                input logic held_o, input int ncyc);
    logic [3:0] an_exp;
    int         idx;
    for (int c = 0; c < ncyc; c++) begin
      idx    = (cyc / 4) % 4;
      an_exp = ~(4'b0001 << idx);
      check_output("valid", bus.valid, (c == 99) ? 32'h1 : 32'h0);
      check_output("an_n", bus.an_n, an_exp);
      check_output("seg_n", bus.seg_n, exp_seg(held_f, held_o, idx));
      check_output("freq_hold", bus.freq_bcd, held_f);
      if ((c % 4 == 1) && ((c - 1) / 4 < rises)) bus.sig_in = 1'b1;
      if ((c % 4 == 3) && ((c - 3) / 4 < rises)) bus.sig_in = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_result(input string name, input logic [15:0] f, input logic o);
    check_output({name, "_freq"}, bus.freq_bcd, f);
    check_output({name, "_ovf"}, bus.ovf, o);
  endtask

  task automatic run_main;
    logic [15:0] held_f;
    logic        held_o;
    bus.sig_in = 1'b0;
    do_reset(3);
    apply_stimulus(0, 16'h0, 1'b0, 100);
    check_result("idle0", 16'h0000, 1'b0);
    apply_stimulus(0, 16'h0, 1'b0, 100);
    check_result("idle1", 16'h0000, 1'b0);

    held_f = 16'h0;
    held_o = 1'b0;
    for (int v = 0; v < 7; v++) begin
      apply_stimulus(vecs[v].rises, held_f, held_o, 100);
      check_result("vec", vecs[v].exp_freq, vecs[v].exp_ovf);
      held_f = vecs[v].exp_freq;
      held_o = vecs[v].exp_ovf;
    end

    $display("[TB] reset in mid-window");
    apply_stimulus(10, held_f, held_o, 50);
    do_reset(2);
    apply_stimulus(3, 16'h0, 1'b0, 100);
    check_result("post_rst", 16'h0003, 1'b0);

    $display("[TB] reset with sig_in held high");
    bus.sig_in = 1'b1;
    do_reset(2);
    apply_stimulus(0, 16'h0, 1'b0, 100);
    check_result("high_rst", 16'h0001, 1'b0);
    bus.sig_in = 1'b0;
  endtask

  // Window 1 carries 10000 edges (saturates); window 2 skips one rise for 9999.
  task automatic run_big;
    rst2        = 1'b1;
    bus2.sig_in = 1'b0;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    for (int c = 0; c <= 80000; c++) begin
      if (c == 20000) check_output("big_hold", bus2.freq_bcd, 32'h0);
      if (c == 39998) check_output("big_valid_early", bus2.valid, 32'h0);
      if (c == 39999 || c == 79999) check_output("big_valid", bus2.valid, 32'h1);
      if (c == 40000) begin
        check_output("big_sat_freq", bus2.freq_bcd, 32'h9999);
        check_output("big_sat_ovf", bus2.ovf, 32'h1);
        check_output("big_sat_seg", bus2.seg_n, 32'h10);
      end
      if (c == 80000) begin
        check_output("big_9999_freq", bus2.freq_bcd, 32'h9999);
        check_output("big_9999_ovf", bus2.ovf, 32'h0);
      end
      if ((c % 4 == 1) && (c != 60001)) bus2.sig_in = 1'b1;
      if (c % 4 == 3) bus2.sig_in = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0] = '{25, 16'h0025, 1'b0};
    vecs[1] = '{0,  16'h0000, 1'b0};
    vecs[2] = '{1,  16'h0001, 1'b0};
    vecs[3] = '{9,  16'h0009, 1'b0};
    vecs[4] = '{10, 16'h0010, 1'b0};
    vecs[5] = '{19, 16'h0019, 1'b0};
    vecs[6] = '{24, 16'h0024, 1'b0};
    rst  = 1'b1;
    rst2 = 1'b1;
    fork
      run_main();
      run_big();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
